input_packer: RTL and testbench

Sits directly upstream of the network input layer. It accepts a serial stream of WV-bit feature elements over a valid/ready handshake, packs NC consecutive elements into one NC*WV-bit input vector, and presents that vector on the valid/ready handshake the input layer consumes. A last-element marker terminates a short vector early and zero-pads the unused slots. Two-stage buffering (assembly register plus output register) sustains one element per cycle while the output is stalled for up to one vector.

---
 rtl/input_packer.sv | 98 +++++++++
 tb/tb_input_packer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_packer.sv
// input_packer: packs NC serial WV-bit elements into one NC*WV-bit vector.
// An assembly register feeds an output register so input keeps flowing under a one-vector stall.
module input_packer #(
  parameter int NC = 7,
  parameter int WV = 5
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iValid_AM_Elem,
  output logic             oReady_AM_Elem,
  input  logic [WV-1:0]    iData_AM_Elem,
  input  logic             iLast_AM_Elem,
  output logic             oValid_BM_Input,
  input  logic             iReady_BM_Input,
  output logic [NC*WV-1:0] oData_BM_Input
);

  localparam int CW = $clog2(NC);
  localparam logic [CW-1:0] LastSlot = CW'(NC - 1);

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cntNext;
  logic [NC*WV-1:0] asmReg;
  logic [NC*WV-1:0] asmNext;
  logic [NC*WV-1:0] outReg;
  logic [NC*WV-1:0] outNext;
  logic             asmFull;
  logic             asmFullNext;
  logic             outValid;
  logic             outValidNext;
  logic             outFree;
  logic             xfer;
  logic             acc;
  logic             done;

  assign outFree = !outValid || iReady_BM_Input;
  assign xfer = asmFull && outFree;
  assign oReady_AM_Elem = !asmFull || outFree;
  assign acc = iValid_AM_Elem && oReady_AM_Elem;
  assign done = (cnt == LastSlot) || iLast_AM_Elem;

  assign oValid_BM_Input = outValid;
  assign oData_BM_Input = outReg;

  // A write to slot 0 starts a fresh vector, so stale upper slots are
  // cleared then; a completing write zero-pads the slots above it.
  always_comb begin
    asmNext = asmReg;
    if (acc) begin
      for (int k = 0; k < NC; k++) begin
        if (CW'(k) == cnt) begin
          asmNext[k*WV +: WV] = iData_AM_Elem;
        end else if (CW'(k) > cnt && (done || cnt == '0)) begin
          asmNext[k*WV +: WV] = '0;
        end
      end
    end
  end

  always_comb begin
    cntNext = cnt;
    asmFullNext = asmFull;
    outNext = outReg;
    outValidNext = outValid;
    if (xfer) begin
      outNext = asmReg;
      outValidNext = 1'b1;
      asmFullNext = 1'b0;
    end else if (outValid && iReady_BM_Input) begin
      outValidNext = 1'b0;
    end
    if (acc) begin
      if (done) begin
        cntNext = '0;
        asmFullNext = 1'b1;
      end else begin
        cntNext = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      cnt <= '0;
      asmReg <= '0;
      asmFull <= 1'b0;
      outReg <= '0;
      outValid <= 1'b0;
    end else begin
      cnt <= cntNext;
      asmReg <= asmNext;
      asmFull <= asmFullNext;
      outReg <= outNext;
      outValid <= outValidNext;
    end
  end

endmodule

// File: tb/tb_input_packer.sv
// tb_input_packer: directed table plus corner-case sequences
// for the serial-to-vector packer.
module tb_input_packer;

  localparam int NC = 7;
  localparam int WV = 5;
  localparam int VW = NC * WV;

  logic          iCLK;
  logic          iRST;
  logic          iValid;
  logic          oReady;
  logic [WV-1:0] iData;
  logic          iLast;
  logic          oValid;
  logic          iReady;
  logic [VW-1:0] oData;

  input_packer #(.NC(NC), .WV(WV)) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .iValid_AM_Elem(iValid),
    .oReady_AM_Elem(oReady),
    .iData_AM_Elem(iData),
    .iLast_AM_Elem(iLast),
    .oValid_BM_Input(oValid),
    .iReady_BM_Input(iReady),
    .oData_BM_Input(oData)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    logic          v;
    logic [WV-1:0] d;
    logic          last;
    logic          rdy;
    logic          expRdy;
    logic          expVal;
    logic [VW-1:0] expData;
  } row_t;

  row_t          tbl[22];
  int            nCmp = 0;
  int            nBad = 0;
  logic          accNow;
  logic          outNow;
  logic [VW-1:0] got[$];

  function automatic logic [VW-1:0] vec7(input int a, input int b,
    input int c, input int d, input int e, input int f, input int g);
    logic [VW-1:0] r;
    r = {g[4:0], f[4:0], e[4:0], d[4:0], c[4:0], b[4:0], a[4:0]};
    return r;
  endfunction

  function automatic row_t mk(input logic v, input int d, input logic l,
    input logic er, input logic ev, input logic [VW-1:0] ed);
    row_t r;
    r.v = v;
    r.d = d[4:0];
    r.last = l;
    r.rdy = 1'b1;
    r.expRdy = er;
    r.expVal = ev;
    r.expData = ed;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
    input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, sample before the rising edge.
  task automatic step(input logic v, input logic [WV-1:0] d,
    input logic l, input logic r);
    iValid = v;
    iData = d;
    iLast = l;
    iReady = r;
    #1;
    accNow = v && oReady;
    outNow = oValid && r;
    if (outNow) got.push_back(oData);
    @(negedge iCLK);
  endtask

  initial begin
    logic [VW-1:0] v1, v2, v3, v4;
    int n;
    int stallBad;
    int drops;
    int idx;
    int used;
    int pulses[$];
    int sv[5];

    iRST = 1'b0;
    iValid = 1'b0;
    iData = '0;
    iLast = 1'b0;
    iReady = 1'b1;
    accNow = 1'b0;
    outNow = 1'b0;

    v1 = vec7(1, 2, 3, 4, 5, 6, 7);
    v2 = vec7(9, 10, 11, 0, 0, 0, 0);
    v3 = vec7(12, 13, 14, 15, 16, 17, 18);
    for (int i = 0; i < 7; i++) tbl[i] = mk(1, i + 1, 0, 1, 0, '0);
    tbl[7]  = mk(1, 9, 0, 1, 0, '0);
    tbl[8]  = mk(1, 10, 0, 1, 1, v1);
    tbl[9]  = mk(1, 11, 1, 1, 0, v1);
    tbl[10] = mk(1, 12, 0, 1, 0, v1);
    tbl[11] = mk(0, 0, 0, 1, 1, v2);
    tbl[12] = mk(0, 0, 0, 1, 0, v2);
    for (int i = 13; i < 19; i++) tbl[i] = mk(1, i, i == 18, 1, 0, v2);
    tbl[19] = mk(0, 0, 0, 1, 0, v2);
    tbl[20] = mk(0, 0, 0, 1, 1, v3);
    tbl[21] = mk(0, 0, 0, 1, 0, v3);

    repeat (2) @(negedge iCLK);
    iRST = 1'b1;
    #1;
    chk("reset.valid", oValid, 0);
    chk("reset.data", oData, 0);
    chk("reset.ready", oReady, 1);
    @(negedge iCLK);

    for (int i = 0; i < 22; i++) begin
      iValid = tbl[i].v;
      iData = tbl[i].d;
      iLast = tbl[i].last;
      iReady = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d.ready", i), oReady, tbl[i].expRdy);
      chk($sformatf("row%0d.valid", i), oValid, tbl[i].expVal);
      chk($sformatf("row%0d.data", i), oData, tbl[i].expData);
      @(negedge iCLK);
    end

    // Backpressure: output stalled, 21 elements offered back to back.
    got.delete();
    n = 1;
    stallBad = 0;
    for (int c = 0; c < 20; c++) begin
      iValid = 1'b1;
      iData = n[4:0];
      iLast = 1'b0;
      iReady = 1'b0;
      #1;
      if (c == 14) chk("bp.readyLow", oReady, 0);
      if (c >= 8 && (oData !== v1 || oValid !== 1'b1)) stallBad++;
      if (oReady) n++;
      @(negedge iCLK);
    end
    chk("bp.accepted", n - 1, 14);
    chk("bp.heldStable", stallBad, 0);
    for (int c = 0; c < 60 && got.size() < 3; c++) begin
      step(n <= 21, n[4:0], 1'b0, 1'b1);
      if (accNow) n++;
    end
    chk("bp.count", got.size(), 3);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("bp.vec%0d", i), got[i],
        vec7(7*i+1, 7*i+2, 7*i+3, 7*i+4, 7*i+5, 7*i+6, 7*i+7));
    repeat (3) step(0, '0, 0, 1);

    // Back-to-back vectors with a continuously valid source.
    got.delete();
    drops = 0;
    for (int c = 0; c < 34; c++) begin
      step(c < 28, c[4:0], 1'b0, 1'b1);
      if (c < 28 && !accNow) drops++;
      if (outNow) pulses.push_back(c);
    end
    chk("b2b.drops", drops, 0);
    chk("b2b.pulses", pulses.size(), 4);
    for (int i = 0; i < pulses.size(); i++)
      chk($sformatf("b2b.pulse%0d", i), pulses[i], 8 + 7 * i);
    chk("b2b.count", got.size(), 4);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("b2b.vec%0d", i), got[i],
        vec7(7*i, 7*i+1, 7*i+2, 7*i+3, 7*i+4, 7*i+5, 7*i+6));

    // Asynchronous reset mid-vector with a stalled valid output.
    for (int i = 1; i <= 7; i++) step(1, i[4:0], 0, 0);
    repeat (2) step(0, '0, 0, 0);
    for (int i = 20; i < 24; i++) step(1, i[4:0], 0, 0);
    iValid = 1'b0;
    #1;
    chk("rst.preValid", oValid, 1);
    #1;
    iRST = 1'b0;
    #1;
    chk("rst.valid", oValid, 0);
    chk("rst.data", oData, 0);
    chk("rst.ready", oReady, 1);
    @(negedge iCLK);
    #2;
    iRST = 1'b1;
    @(negedge iCLK);
    got.delete();
    for (int i = 11; i <= 17; i++) step(1, i[4:0], 0, 1);
    repeat (4) step(0, '0, 0, 1);
    chk("rst.count", got.size(), 1);
    if (got.size() > 0)
      chk("rst.vec", got[0], vec7(11, 12, 13, 14, 15, 16, 17));

    // Single-element vectors, including an all-zero one.
    got.delete();
    sv = '{31, 0, 17, 1, 30};
    idx = 0;
    used = 0;
    for (int c = 0; c < 20 && (idx < 5 || got.size() < 5); c++) begin
      step(idx < 5, sv[idx < 5 ? idx : 0][4:0], 1'b1, 1'b1);
      if (idx < 5) used++;
      if (accNow) idx++;
    end
    chk("single.cycles", used, 5);
    chk("single.count", got.size(), 5);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("single.vec%0d", i), got[i], vec7(sv[i], 0, 0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
